// File: rtl/btn_conditioner.sv
// btn_conditioner: cleans the raw active-low UP, DOWN and SET push-buttons.
// Per key: 2-FF synchroniser, debounce counter, one-cycle press event and a
// pulse stretcher that holds each export long enough for a polled PIO.
// UP and DOWN lock each other out while both are held.
// Optional feature macro: BTN_AUTOREPEAT_EN adds an auto-repeat FSM on UP and
// DOWN (IDLE, DELAY, REPEAT, LOCKED). Without it every debounced press gives
// exactly one event and lockout is tracked by a simple per-key flag.
module btn_conditioner #(
   parameter int DEBOUNCE_CYCLES     = 1000000,
   parameter int STRETCH_CYCLES      = 2500000,
   parameter int REPEAT_DELAY_CYCLES = 25000000,
   parameter int REPEAT_RATE_CYCLES  = 5000000
) (
   input  logic       clk_clk,
   input  logic       reset_reset,
   input  logic       btn_up_n,
   input  logic       btn_down_n,
   input  logic       btn_set_n,
   output logic       btn_up_export,
   output logic       btn_down_export,
   output logic       btn_set_export,
   output logic [2:0] btn_level,
   output logic [2:0] btn_evt
);

   localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int ST_W = $clog2(STRETCH_CYCLES + 1);
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [ST_W-1:0] ST_LOAD = ST_W'(STRETCH_CYCLES);

   // Elaboration-time guard against parameter values the counters cannot honour.
   generate
      if (DEBOUNCE_CYCLES < 1 || STRETCH_CYCLES < 1 ||
          REPEAT_DELAY_CYCLES < 1 || REPEAT_RATE_CYCLES < 1) begin : g_bad_cfg
         $error("btn_conditioner: cycle parameters must all be at least 1");
      end
   endgenerate

   // Key index order everywhere: [0]=UP, [1]=DOWN, [2]=SET.
   logic [2:0]      raw_act;
   logic [2:0]      sync1;
   logic [2:0]      sync2;
   logic [2:0]      stable;
   logic [2:0]      level_q;
   logic [2:0]      base_evt;
   logic [2:0]      key_evt;
   logic [DB_W-1:0] db_cnt [3];
   logic [ST_W-1:0] st_cnt [3];
   logic            lock;
   logic [1:0]      locked;
   logic [1:0]      rpt_evt;

   assign raw_act = ~{btn_set_n, btn_down_n, btn_up_n};

   // Two-stage synchroniser; reset value 0 means "released".
   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= raw_act;
         sync2 <= sync1;
      end
   end

   // Debounce: accept the synchronised level after DEBOUNCE_CYCLES consecutive mismatches.
   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         stable <= '0;
         for (int k = 0; k < 3; k++) db_cnt[k] <= '0;
      end else begin
         for (int k = 0; k < 3; k++) begin
            if (sync2[k] == stable[k]) begin
               db_cnt[k] <= '0;
            end else if (db_cnt[k] == DB_LAST) begin
               stable[k] <= sync2[k];
               db_cnt[k] <= '0;
            end else begin
               db_cnt[k] <= db_cnt[k] + DB_W'(1);
            end
         end
      end
   end

   // Previous debounced level, for rising-edge detection.
   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) level_q <= '0;
      else             level_q <= stable;
   end

   assign base_evt = stable & ~level_q;
   assign lock     = stable[0] & stable[1];

`ifdef BTN_AUTOREPEAT_EN
   typedef enum logic [1:0] {
      RPT_IDLE   = 2'd0,
      RPT_DELAY  = 2'd1,
      RPT_REPEAT = 2'd2,
      RPT_LOCKED = 2'd3
   } rpt_state_t;

   localparam int RP_MAX = (REPEAT_DELAY_CYCLES > REPEAT_RATE_CYCLES) ?
                           REPEAT_DELAY_CYCLES : REPEAT_RATE_CYCLES;
   localparam int RP_W   = $clog2(RP_MAX + 1);
   // Counters load N-1 on entry so that expiry (count==0) lands N cycles after the trigger.
   localparam logic [RP_W-1:0] RP_DLY  = RP_W'(REPEAT_DELAY_CYCLES - 1);
   localparam logic [RP_W-1:0] RP_RATE = RP_W'(REPEAT_RATE_CYCLES - 1);

   for (genvar k = 0; k < 2; k++) begin : g_rpt
      rpt_state_t      state_q;
      rpt_state_t      state_d;
      logic [RP_W-1:0] cnt_q;
      logic [RP_W-1:0] cnt_d;
      logic            fire;

      // Repeat FSM state and counter registers.
      always_ff @(posedge clk_clk or posedge reset_reset) begin
         if (reset_reset) begin
            state_q <= RPT_IDLE;
            cnt_q   <= '0;
         end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
         end
      end

      // Next state: release wins over lockout, lockout wins over timing.
      always_comb begin
         state_d = state_q;
         cnt_d   = cnt_q;
         fire    = 1'b0;
         if (!stable[k]) begin
            state_d = RPT_IDLE;
            cnt_d   = '0;
         end else if (lock) begin
            state_d = RPT_LOCKED;
            cnt_d   = '0;
         end else begin
            case (state_q)
               RPT_IDLE: begin
                  if (base_evt[k]) begin
                     state_d = RPT_DELAY;
                     cnt_d   = RP_DLY;
                  end
               end
               RPT_DELAY, RPT_REPEAT: begin
                  if (cnt_q == '0) begin
                     fire    = 1'b1;
                     state_d = RPT_REPEAT;
                     cnt_d   = RP_RATE;
                  end else begin
                     cnt_d = cnt_q - RP_W'(1);
                  end
               end
               RPT_LOCKED: state_d = RPT_LOCKED;
               default:    state_d = RPT_IDLE;
            endcase
         end
      end

      assign rpt_evt[k] = fire;
      assign locked[k]  = (state_q == RPT_LOCKED);
   end
`else
   logic [1:0] locked_q;

   // Lockout memory: set while both keys are down, cleared only by releasing the key itself.
   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         locked_q <= '0;
      end else begin
         for (int k = 0; k < 2; k++) begin
            if (!stable[k])  locked_q[k] <= 1'b0;
            else if (lock)   locked_q[k] <= 1'b1;
         end
      end
   end

   assign locked  = locked_q;
   assign rpt_evt = '0;
`endif

   // UP/DOWN events are blocked during lockout and until each locked key is released.
   assign key_evt[1:0] = (base_evt[1:0] | rpt_evt) & ~({2{lock}} | locked);
   assign key_evt[2]   = base_evt[2];

   // Stretcher: each event (re)loads the counter, export is high while it is non-zero.
   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         for (int k = 0; k < 3; k++) st_cnt[k] <= '0;
      end else begin
         for (int k = 0; k < 3; k++) begin
            if (key_evt[k])            st_cnt[k] <= ST_LOAD;
            else if (st_cnt[k] != '0)  st_cnt[k] <= st_cnt[k] - ST_W'(1);
         end
      end
   end

   assign btn_up_export   = (st_cnt[0] != '0);
   assign btn_down_export = (st_cnt[1] != '0);
   assign btn_set_export  = (st_cnt[2] != '0);
   assign btn_level       = stable;
   assign btn_evt         = key_evt;

endmodule
